// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU: word RAM plus a small MMIO window
// (cycle counter, debug transmit FIFO, status and drop counter) and a host access port.
module mem_responder #(
  parameter int MEM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic [31:0]                   mem_addr,
  input  logic                          wr_en,
  input  logic [31:0]                   w_data,
  output logic [31:0]                   r_data,
  input  logic                          host_we,
  input  logic [$clog2(MEM_WORDS)-1:0]  host_addr,
  input  logic [31:0]                   host_wdata,
  output logic [31:0]                   host_rdata,
  input  logic                          host_pop,
  output logic                          host_valid,
  output logic [31:0]                   host_data
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;

  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_DBG_TX = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_DROPS  = 8'h0C;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          is_mmio;
  logic [7:0]    mmio_off;
  logic [AW-1:0] word_idx;
  logic          cpu_we;
  logic          unused_addr_bits;

  assign is_mmio          = (mem_addr[31:8] == 24'hFFFFFF);
  assign mmio_off         = mem_addr[7:0];
  assign word_idx         = mem_addr[AW+1:2];
  assign cpu_we           = clk_en & wr_en;
  assign unused_addr_bits = ^mem_addr[1:0];

  // ---------------------------------------------------------------------------
  // Word RAM: single write port, two combinational read ports
  // ---------------------------------------------------------------------------
  logic [31:0] ram [MEM_WORDS];

  // The host owns the write port when it asks for it; a concurrent CPU RAM store is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (host_we)
        ram[host_addr] <= host_wdata;
      else if (cpu_we && !is_mmio)
        ram[word_idx] <= w_data;
    end
  end

  assign host_rdata = ram[host_addr];

  // ---------------------------------------------------------------------------
  // Debug transmit FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [FW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          drop;

  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign push_req   = cpu_we && is_mmio && (mmio_off == OFF_DBG_TX);
  assign pop        = host_pop && !fifo_empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (push_ok)
      wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)
      rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push_ok)
      fifo_mem[wr_ptr_reg] <= w_data;
  end

  assign host_valid = !fifo_empty;
  assign host_data  = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Cycle and drop counters
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_reg, cycle_next;
  logic [31:0] drops_reg, drops_next;

  always_comb begin
    cycle_next = cycle_reg;
    drops_next = drops_reg;
    if (clk_en)
      cycle_next = cycle_reg + 32'd1;
    if (drop && (drops_reg != 32'hFFFF_FFFF))
      drops_next = drops_reg + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_reg <= '0;
      drops_reg <= '0;
    end else begin
      cycle_reg <= cycle_next;
      drops_reg <= drops_next;
    end
  end

  // ---------------------------------------------------------------------------
  // CPU read mux
  // ---------------------------------------------------------------------------
  logic [31:0] status_word;

  always_comb begin
    status_word          = '0;
    status_word[0]       = fifo_full;
    status_word[1]       = fifo_empty;
    status_word[8 +: CW] = count_reg;
  end

  always_comb begin
    r_data = '0;
    if (is_mmio) begin
      case (mmio_off)
        OFF_CYCLE:  r_data = cycle_reg;
        OFF_STATUS: r_data = status_word;
        OFF_DROPS:  r_data = drops_reg;
        default:    r_data = '0;
      endcase
    end else begin
      r_data = ram[word_idx];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: expected values are queued as stimulus is
// applied and compared in order as the DUT outputs are sampled.
module tb_mem_responder;

  localparam int MEM_WORDS  = 256;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = $clog2(MEM_WORDS);

  logic          clk;
  logic          rst;
  logic          clk_en;
  logic [31:0]   mem_addr;
  logic          wr_en;
  logic [31:0]   w_data;
  logic [31:0]   r_data;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic [31:0]   host_rdata;
  logic          host_pop;
  logic          host_valid;
  logic [31:0]   host_data;

  int n_checks = 0;
  int n_errors = 0;

  string       tag_q [$];
  logic [31:0] exp_q [$];

  mem_responder #(
    .MEM_WORDS  (MEM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .mem_addr   (mem_addr),
    .wr_en      (wr_en),
    .w_data     (w_data),
    .r_data     (r_data),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_pop   (host_pop),
    .host_valid (host_valid),
    .host_data  (host_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic compare_next(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    check("sb_has_entry", 32'(tag_q.size() != 0), 32'd1);
    if (tag_q.size() != 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, obs, e);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clk_en  = 1'b0;
    wr_en   = 1'b0;
    host_we = 1'b0;
    host_pop = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [31:0] addr, input logic [31:0] e);
    mem_addr = addr;
    wr_en    = 1'b0;
    expect_val(tag, e);
    #1;
    compare_next(r_data);
  endtask

  task automatic host_read(input string tag, input logic [AW-1:0] idx, input logic [31:0] e);
    host_addr = idx;
    expect_val(tag, e);
    #1;
    compare_next(host_rdata);
  endtask

  task automatic fifo_head(input string tag, input logic v, input logic [31:0] d);
    expect_val({tag, "_valid"}, {31'b0, v});
    expect_val({tag, "_data"}, d);
    #1;
    compare_next({31'b0, host_valid});
    compare_next(host_data);
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data, input logic en);
    mem_addr = addr;
    w_data   = data;
    wr_en    = 1'b1;
    clk_en   = en;
    tick();
    idle_inputs();
  endtask

  task automatic host_write(input logic [AW-1:0] idx, input logic [31:0] data);
    host_addr  = idx;
    host_wdata = data;
    host_we    = 1'b1;
    tick();
    host_we = 1'b0;
  endtask

  task automatic do_pop();
    host_pop = 1'b1;
    tick();
    host_pop = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF00;
  localparam logic [31:0] A_DBG    = 32'hFFFF_FF04;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF08;
  localparam logic [31:0] A_DROPS  = 32'hFFFF_FF0C;

  initial begin
    logic [31:0] vals [4];
    rst        = 1'b0;
    mem_addr   = '0;
    w_data     = '0;
    host_addr  = '0;
    host_wdata = '0;
    idle_inputs();
    tick();
    tick();

    // Reset state
    fifo_head("rst_fifo", 1'b0, 32'h0);
    cpu_read("rst_cycle", A_CYCLE, 32'h0);
    cpu_read("rst_drops", A_DROPS, 32'h0);
    cpu_read("rst_status", A_STATUS, 32'h0000_0002);

    // Preload with the CPU stalled
    rst = 1'b1;
    host_write(0, 32'h2008_0005);
    host_write(1, 32'hAC08_0010);
    host_write(16, 32'h1234_5678);
    cpu_read("pre_w0", 32'h0, 32'h2008_0005);
    cpu_read("pre_w1", 32'h4, 32'hAC08_0010);
    host_read("pre_host1", 1, 32'hAC08_0010);

    // CPU store gating and aliasing
    cpu_write(32'h40, 32'hDEAD_BEEF, 1'b0);
    cpu_read("gated_store", 32'h40, 32'h1234_5678);
    cpu_write(32'h40, 32'hDEAD_BEEF, 1'b1);
    cpu_read("store", 32'h40, 32'hDEAD_BEEF);
    cpu_read("alias_rd", 32'h440, 32'hDEAD_BEEF);
    cpu_write(32'h444, 32'hCAFE_0001, 1'b1);
    cpu_read("alias_wr", 32'h44, 32'hCAFE_0001);

    // Read-during-write shows the old value until the edge
    mem_addr = 32'h40;
    w_data   = 32'h0000_0001;
    wr_en    = 1'b1;
    clk_en   = 1'b1;
    expect_val("rdw_old", 32'hDEAD_BEEF);
    #1;
    compare_next(r_data);
    tick();
    idle_inputs();
    cpu_read("rdw_new", 32'h40, 32'h0000_0001);

    // Cycle counter
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      clk_en = (i % 2 == 0);
      tick();
    end
    clk_en = 1'b0;
    cpu_read("cycle5", A_CYCLE, 32'd5);
    pulse_reset();
    cpu_read("cycle_clr", A_CYCLE, 32'd0);

    // FIFO fill and overflow
    vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) cpu_write(A_DBG, vals[i], 1'b1);
    cpu_read("full_status", A_STATUS, 32'h0000_0401);
    fifo_head("full_head", 1'b1, 32'h11);
    cpu_write(A_DBG, 32'h55, 1'b1);
    cpu_read("drops1", A_DROPS, 32'd1);
    cpu_read("ovf_status", A_STATUS, 32'h0000_0401);
    for (int i = 0; i < 4; i++) begin
      fifo_head($sformatf("pop%0d", i), 1'b1, vals[i]);
      do_pop();
    end
    fifo_head("drained", 1'b0, 32'h0);
    cpu_read("empty_status", A_STATUS, 32'h0000_0002);
    do_pop();
    cpu_read("pop_empty_status", A_STATUS, 32'h0000_0002);

    // Full FIFO: push and pop together
    vals = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    for (int i = 0; i < 4; i++) cpu_write(A_DBG, vals[i], 1'b1);
    mem_addr = A_DBG;
    w_data   = 32'h66;
    wr_en    = 1'b1;
    clk_en   = 1'b1;
    host_pop = 1'b1;
    tick();
    idle_inputs();
    cpu_read("fullpp_status", A_STATUS, 32'h0000_0401);
    cpu_read("fullpp_drops", A_DROPS, 32'd1);
    vals = '{32'hA2, 32'hA3, 32'hA4, 32'h66};
    for (int i = 0; i < 4; i++) begin
      fifo_head($sformatf("fullpp_pop%0d", i), 1'b1, vals[i]);
      do_pop();
    end
    fifo_head("fullpp_drained", 1'b0, 32'h0);

    // Empty FIFO: push and pop together
    mem_addr = A_DBG;
    w_data   = 32'h77;
    wr_en    = 1'b1;
    clk_en   = 1'b1;
    host_pop = 1'b1;
    tick();
    idle_inputs();
    fifo_head("emptypp", 1'b1, 32'h77);
    cpu_read("emptypp_status", A_STATUS, 32'h0000_0100);
    do_pop();

    // Host and CPU RAM writes collide
    host_write(3, 32'h3333_3333);
    host_write(5, 32'h5555_5555);
    host_addr  = 3;
    host_wdata = 32'hA;
    host_we    = 1'b1;
    mem_addr   = 32'h14;
    w_data     = 32'hB;
    wr_en      = 1'b1;
    clk_en     = 1'b1;
    tick();
    idle_inputs();
    cpu_read("coll_w3", 32'hC, 32'hA);
    cpu_read("coll_w5", 32'h14, 32'h5555_5555);

    // Unmapped MMIO and write-only register reads
    cpu_read("unmapped_rd", 32'hFFFF_FF10, 32'h0);
    cpu_read("dbgtx_rd", A_DBG, 32'h0);
    cpu_write(32'hFFFF_FF10, 32'h99, 1'b1);
    cpu_read("unmapped_rd2", 32'hFFFF_FF10, 32'h0);
    cpu_read("unmapped_status", A_STATUS, 32'h0000_0002);
    cpu_read("unmapped_drops", A_DROPS, 32'd1);

    // Reset mid-operation with writes presented in the reset cycle
    cpu_write(A_DBG, 32'hB1, 1'b1);
    cpu_write(A_DBG, 32'hB2, 1'b1);
    cpu_read("pre_rst_status", A_STATUS, 32'h0000_0200);
    rst        = 1'b0;
    host_addr  = 0;
    host_wdata = 32'hBAD0_0000;
    host_we    = 1'b1;
    mem_addr   = 32'h4;
    w_data     = 32'hBAD0_0001;
    wr_en      = 1'b1;
    clk_en     = 1'b1;
    tick();
    idle_inputs();
    rst = 1'b1;
    fifo_head("mid_rst", 1'b0, 32'h0);
    cpu_read("mid_rst_w0", 32'h0, 32'h2008_0005);
    cpu_read("mid_rst_w1", 32'h4, 32'hAC08_0010);
    cpu_read("mid_rst_drops", A_DROPS, 32'd0);
    cpu_read("mid_rst_cycle", A_CYCLE, 32'd0);

    check("sb_drained", 32'(tag_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
